// File: rtl/bios_loader.sv
// bios_loader: pairs data_io download bytes into 16-bit words, buffers them in a two-bank
// ping-pong RAM and bursts each full bank to the system. BIOS_PAD_EN pads the tail bank with 0xFF.
module bios_loader #(
  parameter int BANK_WORDS = 64,
  parameter int ADDR_W     = 14
) (
  input  logic              clk_sdr,
  input  logic              rst_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ADDR_W-1:0] bios_addr,
  output logic [15:0]       bios_din,
  output logic              bios_wr,
  input  logic              bios_req,
  output logic              bios_loaded,
  output logic              overrun
);
  localparam int AW = $clog2(BANK_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_OFFER, R_XFER} rdState_e;

  logic [15:0]       mem [2*BANK_WORDS];
  rdState_e          rdState_q, rdState_d;
  logic              rdBank_q, rdBank_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [ADDR_W-1:0] wordCnt_q, wordCnt_d;
  logic [ADDR_W-1:0] biosAddr_q, biosAddr_d;
  logic [15:0]       biosDin_q, biosDin_d;
  logic [1:0]        full_q, full_d, fullSet, fullClr;
  logic [7:0]        low_q, low_d;
  logic              reqPrev_q, dlPrev_q;
  logic              ended_q, ended_d;
  logic              loaded_q, loaded_d;
  logic              overrun_q, overrun_d;
  logic              memWe;
  logic [AW:0]       memAddr;
  logic [15:0]       memData;
  logic              dlRise, dlFall, wrBank, wrOdd, releaseNow;
  logic [AW-1:0]     wrWord;
  logic              unusedAddrBits;
`ifdef BIOS_PAD_EN
  typedef enum logic {W_RUN, W_PAD} wrState_e;
  wrState_e          wrState_q, wrState_d;
  logic              padBank_q, padBank_d;
  logic              dirty_q, dirty_d;
  logic              lowValid_q, lowValid_d;
  logic [AW-1:0]     padPtr_q, padPtr_d;
`endif

  assign dlRise         = ioctl_download & ~dlPrev_q;
  assign dlFall         = ~ioctl_download & dlPrev_q;
  assign wrBank         = ioctl_addr[AW+1];
  assign wrWord         = ioctl_addr[AW:1];
  assign wrOdd          = ioctl_addr[0];
  assign releaseNow     = (rdState_q == R_XFER) && reqPrev_q && !bios_req;
  assign unusedAddrBits = ^ioctl_addr[24:AW+2];

  assign bios_addr   = biosAddr_q;
  assign bios_din    = biosDin_q;
  assign bios_wr     = (rdState_q != R_IDLE);
  assign bios_loaded = loaded_q;
  assign overrun     = overrun_q;

  always_comb begin
    rdState_d  = rdState_q;
    rdBank_d   = rdBank_q;
    rdPtr_d    = rdPtr_q;
    wordCnt_d  = wordCnt_q;
    biosAddr_d = biosAddr_q;
    biosDin_d  = biosDin_q;
    low_d      = low_q;
    ended_d    = ended_q;
    loaded_d   = loaded_q;
    overrun_d  = overrun_q;
    fullSet    = '0;
    fullClr    = '0;
    memWe      = 1'b0;
    memAddr    = '0;
    memData    = '0;
`ifdef BIOS_PAD_EN
    wrState_d  = wrState_q;
    padBank_d  = padBank_q;
    dirty_d    = dirty_q;
    lowValid_d = lowValid_q;
    padPtr_d   = padPtr_q;
`endif

    // Reader: a word leaves on every requested cycle, including the one that accepts the offer.
    case (rdState_q)
      R_IDLE: if (full_q[rdBank_q]) rdState_d = R_OFFER;
      R_OFFER, R_XFER: begin
        if (releaseNow) begin
          fullClr[rdBank_q] = 1'b1;
          rdBank_d          = ~rdBank_q;
          rdPtr_d           = '0;
          rdState_d         = R_IDLE;
        end else if (bios_req) begin
          biosDin_d  = mem[{rdBank_q, rdPtr_q}];
          biosAddr_d = wordCnt_q;
          rdPtr_d    = rdPtr_q + AW'(1);
          wordCnt_d  = wordCnt_q + ADDR_W'(1);
          rdState_d  = R_XFER;
        end
      end
      default: rdState_d = R_IDLE;
    endcase

    // A bank still marked full (including one released this cycle) rejects every byte.
    if (ioctl_download && ioctl_wr) begin
      if (full_q[wrBank]) begin
        overrun_d = 1'b1;
      end else if (!wrOdd) begin
        low_d = ioctl_dout;
`ifdef BIOS_PAD_EN
        lowValid_d = 1'b1;
        padBank_d  = wrBank;
        padPtr_d   = wrWord;
        dirty_d    = 1'b1;
`endif
      end else begin
        memWe   = 1'b1;
        memAddr = {wrBank, wrWord};
        memData = {ioctl_dout, low_q};
        if (&wrWord) fullSet[wrBank] = 1'b1;
`ifdef BIOS_PAD_EN
        lowValid_d = 1'b0;
        padBank_d  = wrBank;
        padPtr_d   = wrWord + AW'(1);
        dirty_d    = ~(&wrWord);
`endif
      end
    end

`ifdef BIOS_PAD_EN
    case (wrState_q)
      W_RUN: begin
        if (dlFall) begin
          if (dirty_q) wrState_d = W_PAD;
          else         ended_d   = 1'b1;
        end
      end
      W_PAD: begin
        memWe      = 1'b1;
        memAddr    = {padBank_q, padPtr_q};
        memData    = lowValid_q ? {8'hFF, low_q} : 16'hFFFF;
        lowValid_d = 1'b0;
        padPtr_d   = padPtr_q + AW'(1);
        if (&padPtr_q) begin
          fullSet[padBank_q] = 1'b1;
          dirty_d            = 1'b0;
          ended_d            = 1'b1;
          wrState_d          = W_RUN;
        end
      end
      default: wrState_d = W_RUN;
    endcase
`else
    if (dlFall) ended_d = 1'b1;
`endif

    full_d = (full_q & ~fullClr) | fullSet;
    if (ended_q && (full_q == 2'b00) && (rdState_q == R_IDLE)) loaded_d = 1'b1;

    // A new download wins over everything else in flight, including a byte strobed this cycle.
    if (dlRise) begin
      full_d     = '0;
      wordCnt_d  = '0;
      biosAddr_d = '0;
      loaded_d   = 1'b0;
      overrun_d  = 1'b0;
      ended_d    = 1'b0;
      rdBank_d   = 1'b0;
      rdPtr_d    = '0;
      rdState_d  = R_IDLE;
      memWe      = 1'b0;
`ifdef BIOS_PAD_EN
      wrState_d  = W_RUN;
      dirty_d    = 1'b0;
      lowValid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_sdr or negedge rst_n) begin
    if (!rst_n) begin
      rdState_q  <= R_IDLE;
      rdBank_q   <= 1'b0;
      rdPtr_q    <= '0;
      wordCnt_q  <= '0;
      biosAddr_q <= '0;
      biosDin_q  <= '0;
      full_q     <= '0;
      low_q      <= '0;
      reqPrev_q  <= 1'b0;
      dlPrev_q   <= 1'b0;
      ended_q    <= 1'b0;
      loaded_q   <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef BIOS_PAD_EN
      wrState_q  <= W_RUN;
      padBank_q  <= 1'b0;
      dirty_q    <= 1'b0;
      lowValid_q <= 1'b0;
      padPtr_q   <= '0;
`endif
    end else begin
      rdState_q  <= rdState_d;
      rdBank_q   <= rdBank_d;
      rdPtr_q    <= rdPtr_d;
      wordCnt_q  <= wordCnt_d;
      biosAddr_q <= biosAddr_d;
      biosDin_q  <= biosDin_d;
      full_q     <= full_d;
      low_q      <= low_d;
      reqPrev_q  <= bios_req;
      dlPrev_q   <= ioctl_download;
      ended_q    <= ended_d;
      loaded_q   <= loaded_d;
      overrun_q  <= overrun_d;
`ifdef BIOS_PAD_EN
      wrState_q  <= wrState_d;
      padBank_q  <= padBank_d;
      dirty_q    <= dirty_d;
      lowValid_q <= lowValid_d;
      padPtr_q   <= padPtr_d;
`endif
    end
  end

  always_ff @(posedge clk_sdr) begin
    if (memWe) mem[memAddr] <= memData;
  end

endmodule
